// File: rtl/ecc_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : ecc_scrubber
// Brief    : Background SECDED scrubber sharing one SRAM bank with a
//            functional requester; corrects single-bit errors in idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_scrubber #(
    parameter int unsigned BankSize  = 256,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = $clog2(BankSize),
    parameter int unsigned EncWidth  = DataWidth + $clog2(DataWidth + $clog2(DataWidth) + 1) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 scrub_trigger_i,
    output logic                 bit_corrected_o,
    output logic                 uncorrectable_o,
    output logic [AddrWidth-1:0] scrub_addr_o,
    input  logic                 intc_req_i,
    input  logic                 intc_we_i,
    input  logic [AddrWidth-1:0] intc_add_i,
    input  logic [EncWidth-1:0]  intc_wdata_i,
    output logic [EncWidth-1:0]  intc_rdata_o,
    output logic                 bank_req_o,
    output logic                 bank_we_o,
    output logic [AddrWidth-1:0] bank_add_o,
    output logic [EncWidth-1:0]  bank_wdata_o,
    input  logic [EncWidth-1:0]  bank_rdata_i
);

    localparam int CwWidth  = int'(EncWidth) - 1;
    localparam int ParWidth = CwWidth - int'(DataWidth);

    // Word layout: bit [EncWidth-1] is overall parity, bit p-1 holds Hamming
    // position p; positions that are powers of two carry the check bits.
    function automatic logic [EncWidth-1:0] ecc_encode(input logic [DataWidth-1:0] d);
        logic [EncWidth-1:0] w;
        int                  k;
        w = '0;
        k = 0;
        for (int p = 1; p <= CwWidth; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[p-1] = d[k];
                k++;
            end
        end
        for (int j = 0; j < ParWidth; j++) begin
            for (int p = 1; p <= CwWidth; p++) begin
                if (((p >> j) & 1) == 1 && p != (1 << j)) begin
                    w[(1 << j) - 1] ^= w[p-1];
                end
            end
        end
        w[EncWidth-1] = ^w[CwWidth-1:0];
        return w;
    endfunction

    // Returns {single_error, double_error, corrected_data}.
    function automatic logic [DataWidth+1:0] ecc_decode(input logic [EncWidth-1:0] w);
        logic [ParWidth-1:0] syn;
        logic [EncWidth-1:0] c;
        logic [DataWidth-1:0] d;
        logic                ovr;
        logic                hit;
        logic                sgl;
        logic                dbl;
        int                  k;
        syn = '0;
        for (int p = 1; p <= CwWidth; p++) begin
            if (w[p-1]) syn ^= p[ParWidth-1:0];
        end
        ovr = ^w;
        c   = w;
        hit = 1'b0;
        for (int p = 1; p <= CwWidth; p++) begin
            if (syn == p[ParWidth-1:0]) begin
                c[p-1] = ~c[p-1];
                hit    = 1'b1;
            end
        end
        sgl = 1'b0;
        dbl = 1'b0;
        if (ovr) begin
            // Zero syndrome with odd parity means only the overall bit flipped.
            if (syn == '0 || hit) sgl = 1'b1;
            else                  dbl = 1'b1;
        end else if (syn != '0) begin
            dbl = 1'b1;
        end
        d = '0;
        k = 0;
        for (int p = 1; p <= CwWidth; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = c[p-1];
                k++;
            end
        end
        return {sgl, dbl, d};
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [AddrWidth-1:0] r_addr;
    logic                 r_pending;
    logic [EncWidth-1:0]  r_wb_data;
    logic [AddrWidth-1:0] r_wb_addr;

    logic                 w_pending;
    logic                 w_issue;
    logic                 w_advance;
    logic                 w_latch;
    logic                 w_corr;
    logic                 w_unc;
    logic                 w_scr_req;
    logic                 w_scr_we;
    logic [AddrWidth-1:0] w_scr_add;
    logic                 w_dec_sgl;
    logic                 w_dec_dbl;
    logic [DataWidth-1:0] w_dec_data;
    logic [EncWidth-1:0]  w_reenc;
    logic [AddrWidth-1:0] w_addr_inc;

    assign {w_dec_sgl, w_dec_dbl, w_dec_data} = ecc_decode(bank_rdata_i);
    assign w_reenc    = ecc_encode(w_dec_data);
    assign w_pending  = r_pending | scrub_trigger_i;
    assign w_addr_inc = (r_addr == AddrWidth'(BankSize - 1)) ? '0 : r_addr + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr    <= '0;
            r_pending <= 1'b0;
            r_wb_data <= '0;
            r_wb_addr <= '0;
        end else begin
            r_pending <= w_pending & ~w_issue;
            if (w_advance) r_addr <= w_addr_inc;
            if (w_latch) begin
                r_wb_data <= w_reenc;
                r_wb_addr <= r_addr;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_advance   = 1'b0;
        w_latch     = 1'b0;
        w_corr      = 1'b0;
        w_unc       = 1'b0;
        w_scr_req   = 1'b0;
        w_scr_we    = 1'b0;
        w_scr_add   = r_addr;
        case (r_state)
            S_IDLE: begin
                if (w_pending && !intc_req_i) begin
                    w_scr_req   = 1'b1;
                    w_issue     = 1'b1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_dec_sgl) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_WRITE;
                end else begin
                    w_unc       = w_dec_dbl;
                    w_advance   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                w_scr_add = r_wb_addr;
                // A functional write to the same word makes the writeback stale.
                if (intc_req_i && intc_we_i && intc_add_i == r_wb_addr) begin
                    w_advance   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (!intc_req_i) begin
                    w_scr_req   = 1'b1;
                    w_scr_we    = 1'b1;
                    w_corr      = 1'b1;
                    w_advance   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bank_req_o   = intc_req_i ? 1'b1         : w_scr_req;
    assign bank_we_o    = intc_req_i ? intc_we_i    : w_scr_we;
    assign bank_add_o   = intc_req_i ? intc_add_i   : w_scr_add;
    assign bank_wdata_o = intc_req_i ? intc_wdata_i : r_wb_data;
    assign intc_rdata_o = bank_rdata_i;

    assign bit_corrected_o = w_corr;
    assign uncorrectable_o = w_unc;
    assign scrub_addr_o    = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_ecc_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_scrubber
// Brief    : Directed scoreboard bench for ecc_scrubber with a bank model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_scrubber;

    localparam int BS = 256;
    localparam int DW = 64;
    localparam int AW = 8;
    localparam int CW = 71;
    localparam int PW = 7;
    localparam int EW = 72;

    localparam logic [1:0] K_RD   = 2'd0;
    localparam logic [1:0] K_WR   = 2'd1;
    localparam logic [1:0] K_CORR = 2'd2;
    localparam logic [1:0] K_UNC  = 2'd3;

    typedef struct packed {
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [EW-1:0] data;
        logic [31:0]   cyc;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trig;
    logic          corr, unc;
    logic [AW-1:0] scrub_addr;
    logic          intc_req, intc_we;
    logic [AW-1:0] intc_add;
    logic [EW-1:0] intc_wdata, intc_rdata;
    logic          bank_req, bank_we;
    logic [AW-1:0] bank_add;
    logic [EW-1:0] bank_wdata;
    logic [EW-1:0] bank_rdata = '0;

    logic          s_rst_n, s_trig, s_corr, s_unc;
    logic [1:0]    s_scrub_addr, s_bank_add;
    logic          s_bank_req, s_bank_we;
    logic [EW-1:0] s_intc_rdata, s_bank_wdata;

    logic [EW-1:0] mem [BS];
    ev_t           sb[$];
    logic [2:0]    s_exp[$];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    logic [AW-1:0] exp_addr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ecc_scrubber u_dut (
        .clk_i(clk), .rst_ni(rst_n), .scrub_trigger_i(trig),
        .bit_corrected_o(corr), .uncorrectable_o(unc), .scrub_addr_o(scrub_addr),
        .intc_req_i(intc_req), .intc_we_i(intc_we), .intc_add_i(intc_add),
        .intc_wdata_i(intc_wdata), .intc_rdata_o(intc_rdata),
        .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_add_o(bank_add),
        .bank_wdata_o(bank_wdata), .bank_rdata_i(bank_rdata)
    );

    ecc_scrubber #(.BankSize(4)) u_small (
        .clk_i(clk), .rst_ni(s_rst_n), .scrub_trigger_i(s_trig),
        .bit_corrected_o(s_corr), .uncorrectable_o(s_unc), .scrub_addr_o(s_scrub_addr),
        .intc_req_i(1'b0), .intc_we_i(1'b0), .intc_add_i(2'd0),
        .intc_wdata_i({EW{1'b0}}), .intc_rdata_o(s_intc_rdata),
        .bank_req_o(s_bank_req), .bank_we_o(s_bank_we), .bank_add_o(s_bank_add),
        .bank_wdata_o(s_bank_wdata), .bank_rdata_i({EW{1'b0}})
    );

    // SRAM model with one-cycle read latency.
    always @(posedge clk) begin
        if (bank_req) begin
            if (bank_we) mem[bank_add] = bank_wdata;
            else         bank_rdata <= mem[bank_add];
        end
    end

    // Check bits are chosen so that the XOR of set-bit positions is zero.
    function automatic logic [EW-1:0] enc(input logic [DW-1:0] d);
        logic [EW-1:0] w;
        logic [PW-1:0] syn;
        int            k;
        w = '0;
        syn = '0;
        k = 0;
        for (int p = 1; p <= CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[p-1] = d[k];
                if (d[k]) syn ^= p[PW-1:0];
                k++;
            end
        end
        for (int j = 0; j < PW; j++) w[(1 << j) - 1] = syn[j];
        w[EW-1] = ^w[CW-1:0];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic sb_take(input ev_t obs);
        n_chk++;
        assert (sb.size() != 0) n_pass++;
        else $error("FAIL sb_unexpected: observed %0h expected none", obs);
        if (sb.size() != 0) chk("sb_event", 128'(obs), 128'(sb.pop_front()));
    endtask

    always @(negedge clk) begin
        if (bank_req && !intc_req)
            sb_take(ev_t'{bank_we ? K_WR : K_RD, bank_add, bank_we ? bank_wdata : '0, 32'(cyc)});
        if (corr) sb_take(ev_t'{K_CORR, '0, '0, 32'(cyc)});
        if (unc)  sb_take(ev_t'{K_UNC, '0, '0, 32'(cyc)});
        if (s_bank_req) begin
            n_chk++;
            assert (s_exp.size() != 0) n_pass++;
            else $error("FAIL small_unexpected: observed read %0d expected none", s_bank_add);
            if (s_exp.size() != 0)
                chk("small_read", 128'({s_bank_we, s_bank_add}), 128'(s_exp.pop_front()));
        end
        if (s_corr || s_unc) chk("small_pulse", 128'({s_corr, s_unc}), 128'(0));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] k, input logic [AW-1:0] a, input logic [EW-1:0] d, input int c);
        sb.push_back(ev_t'{k, a, d, 32'(c)});
    endtask

    task automatic adv();
        exp_addr = (exp_addr == AW'(BS - 1)) ? '0 : exp_addr + 1'b1;
    endtask

    // kind: 0 clean, 1 single error (writeback of fixed), 2 double error.
    task automatic step(input int kind, input logic [EW-1:0] fixed);
        int c0;
        tick();
        trig = 1'b1;
        c0 = cyc;
        push(K_RD, exp_addr, '0, c0);
        if (kind == 2) push(K_UNC, '0, '0, c0 + 1);
        if (kind == 1) begin
            push(K_WR, exp_addr, fixed, c0 + 2);
            push(K_CORR, '0, '0, c0 + 2);
        end
        tick();
        trig = 1'b0;
        tick();
        if (kind == 1) tick();
        adv();
        chk("scrub_addr", 128'(scrub_addr), 128'(exp_addr));
    endtask

    task automatic fill_mem();
        for (int i = 0; i < BS; i++) mem[i] = enc({$urandom, $urandom});
    endtask

    initial begin
        logic [EW-1:0] w_clean, w2, w3, w_func, pat;
        int c0;
        rst_n = 1'b0; trig = 1'b0; intc_req = 1'b0; intc_we = 1'b0;
        intc_add = '0; intc_wdata = '0; s_rst_n = 1'b0; s_trig = 1'b0;
        w_clean = enc(64'h0123_4567_89AB_CDEF);
        w2      = enc(64'hDEAD_BEEF_5555_AAAA);
        w3      = enc(64'h0F0F_F0F0_1234_8765);
        w_func  = enc(64'hCAFE_F00D_0000_1111);
        pat     = {8'h5A, 64'h1357_9BDF_2468_ACE0};
        fill_mem();
        mem[0] = w_clean;
        exp_addr = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_bank_req", 128'(bank_req), 128'(0));
        chk("rst_pulses", 128'({corr, unc}), 128'(0));
        chk("rst_scrub_addr", 128'(scrub_addr), 128'(0));
        intc_req = 1'b1; intc_we = 1'b1; intc_add = 8'h33; intc_wdata = pat;
        #1;
        chk("mux_in_reset", 128'({bank_req, bank_we, bank_add, bank_wdata}), 128'({2'b11, 8'h33, pat}));
        intc_req = 1'b0; intc_we = 1'b0;
        tick();
        rst_n = 1'b1;

        step(0, '0);
        for (int a = 1; a < 5; a++) step(0, '0);
        mem[5] = w_clean ^ (72'd1 << 3);
        step(1, w_clean);
        chk("mem5_fixed", 128'(mem[5]), 128'(w_clean));
        step(0, '0);
        mem[7] = w_clean ^ (72'd1 << 3) ^ (72'd1 << 10);
        step(2, '0);
        chk("mem7_untouched", 128'(mem[7]), 128'(w_clean ^ (72'd1 << 3) ^ (72'd1 << 10)));
        step(0, '0);

        // Writeback stalled by four functional reads.
        mem[9] = w2 ^ (72'd1 << 40);
        tick(); trig = 1'b1; c0 = cyc;
        push(K_RD, 8'd9, '0, c0);
        tick(); trig = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            intc_req = 1'b1; intc_we = 1'b0; intc_add = 8'd2; intc_wdata = pat ^ 72'(i);
            @(negedge clk);
            chk("stall_mux", 128'({bank_req, bank_we, bank_add, bank_wdata}), 128'({2'b10, 8'd2, pat ^ 72'(i)}));
            if (i > 0) chk("stall_rdata", 128'(intc_rdata), 128'(mem[2]));
        end
        tick(); intc_req = 1'b0;
        push(K_WR, 8'd9, w2, cyc);
        push(K_CORR, '0, '0, cyc);
        tick();
        adv();
        chk("stall_scrub_addr", 128'(scrub_addr), 128'(8'd10));
        chk("mem9_fixed", 128'(mem[9]), 128'(w2));

        mem[10] = w_clean ^ (72'd1 << 71);
        step(1, w_clean);

        // Reset, walk back to address 9, then collide with a functional write.
        tick(); rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_scrub_addr", 128'(scrub_addr), 128'(0));
        tick(); rst_n = 1'b1;
        exp_addr = '0;
        fill_mem();
        for (int a = 0; a < 9; a++) step(0, '0);
        mem[9] = w3 ^ 72'd1;
        tick(); trig = 1'b1;
        push(K_RD, 8'd9, '0, cyc);
        tick(); trig = 1'b0;
        tick(); intc_req = 1'b1; intc_we = 1'b1; intc_add = 8'd9; intc_wdata = w_func;
        tick(); intc_req = 1'b0; intc_we = 1'b0;
        repeat (2) tick();
        adv();
        chk("drop_scrub_addr", 128'(scrub_addr), 128'(8'd10));
        chk("drop_mem9", 128'(mem[9]), 128'(w_func));

        // Triggers during a step merge into one queued step.
        tick(); trig = 1'b1;
        push(K_RD, 8'd10, '0, cyc);
        push(K_RD, 8'd11, '0, cyc + 2);
        tick(); tick(); tick(); trig = 1'b0;
        tick();
        chk("merge_scrub_addr", 128'(scrub_addr), 128'(8'd12));
        repeat (2) tick();

        // Four-word instance: wrap and reset during CHECK.
        tick(); s_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); s_trig = 1'b1; s_exp.push_back({1'b0, 2'(i)});
            tick(); s_trig = 1'b0;
            tick();
        end
        chk("small_wrap_addr", 128'(s_scrub_addr), 128'(0));
        tick(); s_trig = 1'b1; s_exp.push_back(3'd0);
        tick(); s_trig = 1'b0; s_rst_n = 1'b0;
        @(negedge clk);
        chk("small_rst_state", 128'({s_bank_req, s_scrub_addr}), 128'(0));
        tick(); tick(); s_rst_n = 1'b1;
        repeat (4) tick();
        chk("small_rst_addr", 128'(s_scrub_addr), 128'(0));

        repeat (2) tick();
        chk("sb_drained", 128'(sb.size()), 128'(0));
        chk("small_drained", 128'(s_exp.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
